exu_wb_arbiter: RTL
===================

// Module: exu_wb_arbiter
// PURPOSE
//  Collects ALU, MUL, DIV and LSU results in EXU and drives the single register-file write port.
//  Write port is exu_wb_data/exu_wb_rd_addr/exu_wb_rd_wr_en, consumed by the decode stage for RF write and operand forwarding.
//  Per-unit result queues absorb write-port conflicts.
//  Generates exu_mul_busy/exu_div_busy/exu_lsu_busy/exu_lsu_stall back to decode for issue stalling.
// PARAMETERS
//  QDEPTH   4   entries per unit result queue (power of 2, >=2)
//  TAGW     8   width of instr_tag carried with each result
// PORTS
//  clk               in   1     clock
//  rst               in   1     synchronous reset, active-high
//  alu_vld           in   1     ALU result valid
//  alu_rd/tag/data   in   5/TAGW/XLEN  ALU rd, tag, result
//  mul_vld           in   1     MUL result valid (pipelined unit)
//  mul_rd/tag/data   in   5/TAGW/XLEN  MUL rd, tag, result
//  div_vld           in   1     DIV result valid
//  div_rd/tag/data   in   5/TAGW/XLEN  DIV rd, tag, result
//  lsu_vld           in   1     load result valid
//  lsu_rd/tag/data   in   5/TAGW/XLEN  load rd, tag, data
//  mul_inflight      in   1     MUL pipeline holds an op not yet presented
//  div_inflight      in   1     DIV iteration in progress
//  lsu_inflight      in   1     load outstanding on the bus
//  exu_wb_rd_wr_en   out  1     RF write enable
//  exu_wb_rd_addr    out  5     RF write address
//  exu_wb_data       out  XLEN  RF write data
//  exu_wb_tag        out  TAGW  tag of retiring result
//  exu_mul_busy      out  1     MUL inflight or MUL queue count >= QDEPTH-1
//  exu_div_busy      out  1     DIV inflight or DIV queue non-empty
//  exu_lsu_busy      out  1     LSU inflight or LSU queue non-empty
//  exu_lsu_stall     out  1     LSU queue count >= QDEPTH-1
//  wb_conflict_cnt   out  32    cycles with >1 candidate, saturating
//  wb_overflow_err   out  1     sticky: a vld arrived on a full queue
// BEHAVIOUR
//  - Reset values: all outputs 0; all queues empty; counter 0; error flag 0.
//  - Enqueue on *_vld. rd==0 results are discarded at enqueue: no entry is written and the queue count does not change.
//  - Enqueue while the queue is full, even with a same-cycle dequeue, is an overflow.
//    The entry is dropped and wb_overflow_err is set until rst.
//  - Arbitration among non-empty queue heads uses fixed priority LSU > DIV > MUL > ALU.
//    Exactly one result wins per cycle; the winner is dequeued that cycle.
//  - Output stage is registered. The winner in cycle N drives wr_en/rd/data/tag in cycle N+1.
//    When there is no winner, wr_en=0 in N+1 and rd/data/tag hold their previous values.
//  - Base latency is 2 cycles, vld to wr_en: enqueue at edge N+1, arbitrate in N+1, write in N+2.
//  - Each queue is a circular buffer with rd/wr pointers of log2(QDEPTH)+1 bits; the extra MSB separates full from empty.
//    Pointers wrap modulo 2*QDEPTH.
//  - Enqueue and dequeue in the same cycle on a non-full queue leave the count unchanged.
//  - Per-unit FIFO order is preserved; no ordering is kept across units.
//    WAW safety across units relies on decode stalling on the busy outputs.
//  - busy/stall are combinational from queue counts and inflight inputs, giving 1-entry headroom for in-flight MUL/LSU results.
//  - wb_conflict_cnt increments in any cycle with >=2 candidates and saturates at 32'hFFFF_FFFF.
//  - rst mid-operation flushes all queued results. No write occurs in the cycle after rst deasserts.
// CONFIGURATION
//  EXU_WB_BYPASS_EN defined:
//  - An arriving *_vld whose queue is empty competes in arbitration that same cycle, at its unit's priority.
//  - If it wins, it is written at N+1 and never enqueued. If it loses, it is enqueued as normal.
//  - Best-case latency is 1 cycle.
//  EXU_WB_BYPASS_EN undefined:
//  - Only queue heads compete; latency is always >= 2.
// TESTING
//  - Single ALU result, rd=5, data=32'h1234 at cycle 0: wr_en=1, rd=5, data=32'h1234 at cycle 2 (cycle 1 with EXU_WB_BYPASS_EN).
//  - ALU, MUL, DIV, LSU all vld at the same cycle with rd=1..4: writes in order LSU, DIV, MUL, ALU on 4 consecutive cycles.
//    wb_conflict_cnt=3 afterwards.
//  - MUL vld for 5 cycles back-to-back, QDEPTH=4, LSU vld every cycle (MUL starved):
//    exu_mul_busy rises when MUL count=3; 5th MUL sets wb_overflow_err; exactly 4 MUL writes once LSU stops.
//  - ALU vld with rd=0 and data=32'hDEAD: no wr_en pulse; queue count stays 0.
//  - 3 DIV results queued, rst asserted 1 cycle: no wr_en afterward; all busy=0; counter=0.
//  - 1000 random vld per unit, with no overflow allowed: per-unit write order equals arrival order; total writes = non-zero-rd arrivals.

Source files
------------

// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter: per-unit result queues and a fixed-priority arbiter for the RF write port.
// Ports: clk/rst (sync, active-high); {alu,mul,div,lsu}_{vld,rd,tag,data} result inputs;
//   {mul,div,lsu}_inflight; exu_wb_{rd_wr_en,rd_addr,data,tag} registered write port;
//   exu_{mul,div,lsu}_busy, exu_lsu_stall issue stalls; wb_conflict_cnt; wb_overflow_err.
// Option: define EXU_WB_BYPASS_EN to let a result arriving on an empty queue win the same cycle.
module exu_wb_arbiter #(
  parameter int QDEPTH = 4,
  parameter int TAGW   = 8,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_vld,
  input  logic [4:0]      alu_rd,
  input  logic [TAGW-1:0] alu_tag,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mul_vld,
  input  logic [4:0]      mul_rd,
  input  logic [TAGW-1:0] mul_tag,
  input  logic [XLEN-1:0] mul_data,
  input  logic            div_vld,
  input  logic [4:0]      div_rd,
  input  logic [TAGW-1:0] div_tag,
  input  logic [XLEN-1:0] div_data,
  input  logic            lsu_vld,
  input  logic [4:0]      lsu_rd,
  input  logic [TAGW-1:0] lsu_tag,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mul_inflight,
  input  logic            div_inflight,
  input  logic            lsu_inflight,
  output logic            exu_wb_rd_wr_en,
  output logic [4:0]      exu_wb_rd_addr,
  output logic [XLEN-1:0] exu_wb_data,
  output logic [TAGW-1:0] exu_wb_tag,
  output logic            exu_mul_busy,
  output logic            exu_div_busy,
  output logic            exu_lsu_busy,
  output logic            exu_lsu_stall,
  output logic [31:0]     wb_conflict_cnt,
  output logic            wb_overflow_err
);
  localparam int PW = $clog2(QDEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int EW = 5 + TAGW + XLEN;
  localparam int U_ALU = 0;
  localparam int U_MUL = 1;
  localparam int U_DIV = 2;
  localparam int U_LSU = 3;

  logic [3:0]    w_vld;
  logic [EW-1:0] w_in [4];

  // rd==0 results never reach a queue or the arbiter
  assign w_vld[U_ALU] = alu_vld & (alu_rd != 5'd0);
  assign w_vld[U_MUL] = mul_vld & (mul_rd != 5'd0);
  assign w_vld[U_DIV] = div_vld & (div_rd != 5'd0);
  assign w_vld[U_LSU] = lsu_vld & (lsu_rd != 5'd0);

  assign w_in[U_ALU] = {alu_rd, alu_tag, alu_data};
  assign w_in[U_MUL] = {mul_rd, mul_tag, mul_data};
  assign w_in[U_DIV] = {div_rd, div_tag, div_data};
  assign w_in[U_LSU] = {lsu_rd, lsu_tag, lsu_data};

  logic [EW-1:0] r_mem [4][QDEPTH];
  logic [PW-1:0] r_wp [4];
  logic [PW-1:0] r_rp [4];
  logic [PW-1:0] w_cnt [4];
  logic [EW-1:0] w_src [4];
  logic [3:0]    w_empty;
  logic [3:0]    w_full;
  logic [3:0]    w_cand;
  logic [3:0]    w_grant;
  logic [3:0]    w_deq;
  logic [3:0]    w_byp;
  logic [3:0]    w_enq;
  logic [EW-1:0] w_win;
  logic          w_multi;
  logic          w_ovf;

  logic            r_wr_en;
  logic [4:0]      r_rd;
  logic [TAGW-1:0] r_tag;
  logic [XLEN-1:0] r_data;
  logic [31:0]     r_cnt;
  logic            r_err;

  // empty queue presents the arriving result (only used when bypass is on)
  always_comb begin
    for (int u = 0; u < 4; u++) begin
      w_cnt[u]   = r_wp[u] - r_rp[u];
      w_empty[u] = (w_cnt[u] == '0);
      w_full[u]  = (w_cnt[u] == PW'(QDEPTH));
      w_src[u]   = w_empty[u] ? w_in[u]
                              : r_mem[u][r_rp[u][AW-1:0]];
    end
  end

`ifdef EXU_WB_BYPASS_EN
  assign w_cand = ~w_empty | w_vld;
`else
  assign w_cand = ~w_empty;
`endif

  always_comb begin
    w_grant = 4'b0000;
    priority case (1'b1)
      w_cand[U_LSU]: w_grant[U_LSU] = 1'b1;
      w_cand[U_DIV]: w_grant[U_DIV] = 1'b1;
      w_cand[U_MUL]: w_grant[U_MUL] = 1'b1;
      w_cand[U_ALU]: w_grant[U_ALU] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_win = '0;
    for (int u = 0; u < 4; u++)
      if (w_grant[u]) w_win = w_src[u];
  end

  // a granted empty queue means the arrival was bypassed
  assign w_deq   = w_grant & ~w_empty;
  assign w_byp   = w_grant & w_empty;
  assign w_enq   = w_vld & ~w_full & ~w_byp;
  assign w_ovf   = |(w_vld & w_full);
  assign w_multi = |(w_cand & (w_cand - 4'd1));

  always_ff @(posedge clk) begin
    for (int u = 0; u < 4; u++)
      if (w_enq[u]) r_mem[u][r_wp[u][AW-1:0]] <= w_in[u];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < 4; u++) begin
        r_wp[u] <= '0;
        r_rp[u] <= '0;
      end
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (w_enq[u]) r_wp[u] <= r_wp[u] + PW'(1);
        if (w_deq[u]) r_rp[u] <= r_rp[u] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wr_en <= |w_grant;
      if (|w_grant) {r_rd, r_tag, r_data} <= w_win;
      if (w_multi && (r_cnt != '1)) r_cnt <= r_cnt + 32'd1;
      if (w_ovf) r_err <= 1'b1;
    end
  end

  assign exu_wb_rd_wr_en = r_wr_en;
  assign exu_wb_rd_addr  = r_rd;
  assign exu_wb_data     = r_data;
  assign exu_wb_tag      = r_tag;
  assign wb_conflict_cnt = r_cnt;
  assign wb_overflow_err = r_err;

  // one slot of headroom for a result already in the MUL/LSU pipe
  assign exu_mul_busy  = mul_inflight
                       | (w_cnt[U_MUL] >= PW'(QDEPTH - 1));
  assign exu_div_busy  = div_inflight | ~w_empty[U_DIV];
  assign exu_lsu_busy  = lsu_inflight | ~w_empty[U_LSU];
  assign exu_lsu_stall = (w_cnt[U_LSU] >= PW'(QDEPTH - 1));
endmodule
